noc_inject_arbiter: RTL

//  Injection-side scheduler for one network send port (putFlit/getCredits pair) of the 3x3 mesh.

---
 rtl/noc_pkg.sv | 45 ++++
 rtl/noc_inject_arbiter_if.sv | 25 ++
 rtl/noc_rr_arbiter.sv | 33 +++
 rtl/noc_inject_arbiter.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared types and sizing for the NoC injection arbiter: flit and credit
// formats, FSM state encoding and derived widths.
package noc_pkg;

  localparam int NUM_REQ   = 4;   // local requesters sharing the send port
  localparam int NUM_VCS   = 2;   // virtual channels at the router input
  localparam int BUF_DEPTH = 4;   // router buffer depth per VC = initial credits
  localparam int DEST_W    = 4;   // destination node id width
  localparam int DATA_W    = 32;  // payload width

  localparam int REQ_W  = $clog2(NUM_REQ);
  localparam int VC_W   = $clog2(NUM_VCS);
  localparam int CRED_W = $clog2(BUF_DEPTH + 1);
  localparam int FLIT_W = 2 + DEST_W + VC_W + DATA_W;

  typedef logic [REQ_W-1:0]  req_idx_t;
  typedef logic [VC_W-1:0]   vc_t;
  typedef logic [CRED_W-1:0] cred_t;

  // Field order fixes the bit offsets on the router's flit_in port.
  typedef struct packed {
    logic              valid;
    logic              tail;
    logic [DEST_W-1:0] dest;
    vc_t               vc;
    logic [DATA_W-1:0] data;
  } flit_t;

  // Credit return from the router: {valid, vc}.
  typedef struct packed {
    logic valid;
    vc_t  vc;
  } credit_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Round-robin successor of a requester index, wrapping at NUM_REQ.
  function automatic req_idx_t next_req(req_idx_t i);
    return (int'(i) == NUM_REQ - 1) ? '0 : req_idx_t'(int'(i) + 1);
  endfunction

endpackage

// File: rtl/noc_inject_arbiter_if.sv
// Local-source and router-side signals of one injection port.
// master: requesters plus router credit return; slave: the arbiter.
interface noc_inject_arbiter_if;
  import noc_pkg::*;

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_tail;
  logic [NUM_REQ-1:0][DEST_W-1:0] req_dest;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_ready;
  flit_t                          flit_out;
  logic                           flit_out_en;
  credit_t                        credit_in;

  modport master (
    output req_valid, req_tail, req_dest, req_data, credit_in,
    input  req_ready, flit_out, flit_out_en
  );

  modport slave (
    input  req_valid, req_tail, req_dest, req_data, credit_in,
    output req_ready, flit_out, flit_out_en
  );

endinterface

// File: rtl/noc_rr_arbiter.sv
// Rotating-priority arbiter: one-hot grant to the first requester at or
// after ptr, wrapping around.
module noc_rr_arbiter
  import noc_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  req_idx_t           ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic     found;
  int       pos;
  req_idx_t idx;

  // Scan from ptr upwards and keep only the first hit.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    grant = '0;
    found = 1'b0;
    pos   = 0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      idx = req_idx_t'(pos);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Injection-side scheduler for one mesh send port: packet-atomic round-robin
// grants, VC allocation on head flits and per-VC credit tracking.
module noc_inject_arbiter
  import noc_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST_N,
  noc_inject_arbiter_if.slave  bus,
  output logic                 busy,
  output logic                 err_credit_ovf
);

  state_t             state;
  req_idx_t           rr_ptr;
  req_idx_t           owner;
  logic [DEST_W-1:0]  lat_dest;
  vc_t                lat_vc;
  cred_t              credit [NUM_VCS];

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] ready;
  logic               any_credit;
  vc_t                free_vc;
  req_idx_t           sel;
  logic               xfer;
  vc_t                send_vc;
  logic [DEST_W-1:0]  send_dest;
  flit_t              next_flit;
  logic [NUM_VCS-1:0] cred_dec;
  logic [NUM_VCS-1:0] cred_inc;

  // Lowest-index VC that still has credit; scanning downwards lets it win.
  always_comb begin
    any_credit = 1'b0;
    free_vc    = '0;
    for (int v = NUM_VCS - 1; v >= 0; v--) begin
      if (credit[v] != '0) begin
        any_credit = 1'b1;
        free_vc    = vc_t'(v);
      end
    end
  end

  // New packets compete only while idle and some VC can take a head flit.
  assign arb_req = (state == IDLE && any_credit) ? bus.req_valid : '0;

  noc_rr_arbiter u_rr (
    .req   (arb_req),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // Ready: arbiter grant when idle, otherwise only the owner with credit on its VC.
  always_comb begin
    ready = '0;
    if (state == IDLE) begin
      ready = grant;
    end else if (credit[lat_vc] != '0) begin
      ready[owner] = bus.req_valid[owner];
    end
  end

  assign bus.req_ready = ready;
  assign xfer          = |ready;
  assign busy          = (state == LOCKED);

  // Encode the accepting requester and assemble the outgoing flit.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ready[i]) sel = req_idx_t'(i);
    end
    send_vc        = (state == IDLE) ? free_vc : lat_vc;
    send_dest      = (state == IDLE) ? bus.req_dest[sel] : lat_dest;
    next_flit.valid = 1'b1;
    next_flit.tail  = bus.req_tail[sel];
    next_flit.dest  = send_dest;
    next_flit.vc    = send_vc;
    next_flit.data  = bus.req_data[sel];
  end

  // Per-VC send and return strobes for the credit counters.
  always_comb begin
    for (int v = 0; v < NUM_VCS; v++) begin
      cred_dec[v] = xfer && (send_vc == vc_t'(v));
      cred_inc[v] = bus.credit_in.valid && (bus.credit_in.vc == vc_t'(v));
    end
  end

  // Packet FSM, round-robin pointer and registered flit output.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      owner           <= '0;
      lat_dest        <= '0;
      lat_vc          <= '0;
      bus.flit_out    <= '0;
      bus.flit_out_en <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      bus.flit_out    <= xfer ? next_flit : '0;
      bus.flit_out_en <= xfer;
      if (xfer) begin
        unique case (state)
          IDLE: begin
            owner    <= sel;
            lat_dest <= send_dest;
            lat_vc   <= send_vc;
            if (bus.req_tail[sel]) rr_ptr <= next_req(sel);
            else                   state  <= LOCKED;
          end
          LOCKED: begin
            if (bus.req_tail[owner]) begin
              state  <= IDLE;
              rr_ptr <= next_req(owner);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Credit counters: -1 on send, +1 on return, saturating with a sticky error.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // NOTE: the counter array must be reset explicitly; it starts full, not at zero.
      for (int v = 0; v < NUM_VCS; v++) credit[v] <= cred_t'(BUF_DEPTH);
      err_credit_ovf <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        if (cred_inc[v] && !cred_dec[v]) begin
          if (credit[v] == cred_t'(BUF_DEPTH)) err_credit_ovf <= 1'b1;
          else                                 credit[v] <= credit[v] + cred_t'(1);
        end else if (cred_dec[v] && !cred_inc[v]) begin
          credit[v] <= credit[v] - cred_t'(1);
        end
      end
    end
  end

endmodule
